// File: rtl/booth_sequencer.sv
// booth_sequencer: radix-2 Booth control FSM with run-skipping multi-bit shifts
module booth_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] mplier,
  output logic             load,
  output logic             add_en,
  output logic             sub_en,
  output logic             shift,
  output logic [4:0]       amount,
  output logic             busy,
  output logic             done
);
  typedef enum logic [2:0] {IDLE, LOAD, EVAL, ARITH, SETTLE, SHIFT, DONE} state_t;
  state_t state, next;
  logic [7:0] q_r;
  logic [3:0] pos, pos_next, run;
  logic       op_sub, b, p, go;
  always_comb begin
    b = q_r[pos[2:0]];
    p = (pos == 4'd0) ? 1'b0 : q_r[pos[2:0] - 3'd1];
    run = 4'd1;
    go = 1'b1;
    for (int i = 1; i < 8; i++) begin
      go = go && (int'(pos) + i < 8) && (q_r[pos[2:0] + 3'(i)] == b);
      run = go ? run + 4'd1 : run;
    end
  end
  always_comb begin
    next = IDLE;
    case (state)
      IDLE:   next = start ? LOAD : IDLE;
      LOAD:   next = EVAL;
      EVAL:   next = (b != p) ? ARITH : SETTLE;
      ARITH:  next = SHIFT;
      SETTLE: next = SHIFT;
      SHIFT:  next = (pos_next == 4'd8) ? DONE : EVAL;
      default: next = IDLE;
    endcase
  end
  // amount is latched at the end of EVAL so it is stable across the following falling edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      q_r <= '0;
      pos <= '0;
      pos_next <= '0;
      amount <= '0;
      op_sub <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE && start) begin
        q_r <= mplier[7:0];
        pos <= '0;
      end
      if (state == EVAL) begin
        amount <= {1'b0, run};
        pos_next <= pos + run;
        op_sub <= b;
      end
      if (state == SHIFT) pos <= pos_next;
    end
  end
  assign load   = state == LOAD;
  assign add_en = state == ARITH && !op_sub;
  assign sub_en = state == ARITH && op_sub;
  assign shift  = state == SHIFT;
  assign busy   = state != IDLE;
  assign done   = state == DONE;
endmodule

// File: tb/tb_booth_sequencer.sv
// tb_booth_sequencer: scoreboard bench; expected command trace derived from multiplier bit runs
module tb_booth_sequencer;
  logic clk = 0, reset_n = 0, start = 0;
  logic [7:0] mplier = 0;
  logic load, add_en, sub_en, shift, busy, done;
  logic [4:0] amount;
  int cyc = 0, checks = 0, errors = 0;
  logic [4:0] last_amt = 0;
  localparam logic [4:0] K_LOAD = 5'b10000, K_ADD = 5'b01000, K_SUB = 5'b00100,
                         K_SH = 5'b00010, K_DN = 5'b00001;
  typedef struct { int t; logic [4:0] kind; logic [4:0] amt; } ev_t;
  ev_t exp_q[$];

  booth_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mplier(mplier),
    .load(load), .add_en(add_en), .sub_en(sub_en), .shift(shift),
    .amount(amount), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h want %0h", name, cyc, act, want);
    end
  endtask

  task automatic push(input int t, input logic [4:0] kind, input logic [4:0] amt);
    ev_t e;
    e.t = t; e.kind = kind; e.amt = amt;
    exp_q.push_back(e);
  endtask

  // reference: split the multiplier into runs of equal bits; each run is one scan step
  task automatic model(input logic [7:0] m, input int a);
    int pos = 0, step = 0, run;
    logic b, prev = 1'b0;
    logic [4:0] amt = last_amt;
    push(a, K_LOAD, amt);
    while (pos < 8) begin
      b = m[pos];
      run = 0;
      while (pos + run < 8 && m[pos + run] == b) run++;
      amt = 5'(run);
      if (b != prev) push(a + 2 + 3 * step, b ? K_SUB : K_ADD, amt);
      push(a + 3 + 3 * step, K_SH, amt);
      prev = b;
      pos += run;
      step++;
    end
    push(a + 1 + 3 * step, K_DN, amt);
    last_amt = amt;
  endtask

  always @(negedge clk) begin
    ev_t e;
    logic [4:0] kind;
    kind = {load, add_en, sub_en, shift, done};
    if (kind != 0) begin
      if (exp_q.size() == 0) chk("unexpected_cmd", int'(kind), 0);
      else begin
        e = exp_q.pop_front();
        chk("cmd_cycle", cyc, e.t);
        chk("cmd_kind", int'(kind), int'(e.kind));
        chk("cmd_amount", int'(amount), int'(e.amt));
        chk("cmd_busy", int'(busy), 1);
      end
    end
  end

  task automatic accept(input logic [7:0] m, output int a);
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    start = 1;
    mplier = m;
    @(posedge clk);
    #1;
    a = cyc;
    start = 0;
    mplier = 8'($urandom);
    model(m, a);
  endtask

  task automatic run_op(input logic [7:0] m, input bit disturb);
    int a;
    bit seen = 0;
    accept(m, a);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = done;
      start = (disturb && !done) ? 1'($urandom) : 1'b0;
      mplier = 8'($urandom);
    end
    start = 0;
    chk("done_seen", int'(seen), 1);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int a;
    repeat (2) @(negedge clk);
    chk("reset_outs", int'({load, add_en, sub_en, shift, done, busy, amount}), 0);
    reset_n = 1;
    run_op(8'h00, 0);
    run_op(8'hFF, 0);
    run_op(8'h0F, 0);
    run_op(8'h06, 0);
    run_op(8'h55, 0);
    run_op(8'h55, 1);
    run_op(8'h06, 1);
    for (int i = 0; i < 30; i++) run_op(8'($urandom), i[0]);
    accept(8'h55, a);
    repeat (3) @(negedge clk);
    #1;
    reset_n = 0;
    #1;
    chk("async_reset_outs", int'({load, add_en, sub_en, shift, done, busy, amount}), 0);
    exp_q.delete();
    last_amt = 0;
    repeat (2) @(negedge clk);
    chk("reset_hold_idle", int'({load, add_en, sub_en, shift, done, busy}), 0);
    reset_n = 1;
    run_op(8'h0F, 0);
    run_op(8'h80, 0);
    run_op(8'h7F, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
